fxp_mac: RTL

FXP_MAC -- requirements
Module: fxp_mac

---
 rtl/fxp_mac_pkg.sv | 19 +
 rtl/fxp_mac_if.sv | 28 ++
 rtl/fxp_mac_adder.sv | 52 +++++
 rtl/fxp_mac.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fxp_mac_pkg.sv
// Shared definitions for the fixed-point multiply-accumulate block:
// FSM state encoding, default format constants and the saturation value.
package fxp_mac_pkg;

  localparam int DEF_Q = 15;
  localparam int DEF_N = 32;

  // Widest word supported; narrower users slice the low bits of SAT_MAG.
  localparam int MAX_N = 64;
  localparam logic [MAX_N-2:0] SAT_MAG = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fxp_mac_if.sv
// Operand/result bus of the MAC: operand handshake, clear, and the
// accumulator result with its valid pulse and sticky overflow flag.
interface fxp_mac_if
  import fxp_mac_pkg::*;
#(
  parameter int N = DEF_N
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         clear;
  logic [N-1:0] acc_out;
  logic         out_valid;
  logic         overflow;

  modport master (
    output in_valid, a, b, clear,
    input  in_ready, acc_out, out_valid, overflow
  );

  modport slave (
    input  in_valid, a, b, clear,
    output in_ready, acc_out, out_valid, overflow
  );

endinterface

// File: rtl/fxp_mac_adder.sv
// Combinational sign-magnitude adder. Reports the magnitude carry of a
// same-sign add; saturation is left to the caller.
module adder
  import fxp_mac_pkg::*;
#(
  parameter int Q = DEF_Q,
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry
);

  localparam int IW = N - 1 - Q;

  logic [N-2:0] am;
  logic [N-2:0] bm;
  logic [Q:0]   frac_s;
  logic [IW:0]  int_s;
  logic [N-2:0] mag;
  logic         sign;

  assign am = a[N-2:0];
  assign bm = b[N-2:0];

  // Same signs add the fraction and integer fields (carry chained between them);
  // opposite signs subtract the smaller magnitude from the larger one.
  always_comb begin
    frac_s = {1'b0, am[Q-1:0]} + {1'b0, bm[Q-1:0]};
    int_s  = {1'b0, am[N-2:Q]} + {1'b0, bm[N-2:Q]} + {{IW{1'b0}}, frac_s[Q]};
    carry  = 1'b0;
    mag    = '0;
    sign   = 1'b0;
    if (a[N-1] == b[N-1]) begin
      mag   = {int_s[IW-1:0], frac_s[Q-1:0]};
      carry = int_s[IW];
      sign  = a[N-1];
    end else if (am >= bm) begin
      mag  = am - bm;
      sign = a[N-1];
    end else begin
      mag  = bm - am;
      sign = b[N-1];
    end
    if (mag == '0) begin
      sign = 1'b0;
    end
    sum = {sign, mag};
  end

endmodule

// File: rtl/fxp_mac.sv
// Sign-magnitude fixed-point multiply-accumulate. A shift-add multiplier
// walks one bit of b per cycle; the truncated, saturated product is then
// added into the accumulator by the shared adder.
module fxp_mac
  import fxp_mac_pkg::*;
#(
  parameter int Q = DEF_Q,
  parameter int N = DEF_N
) (
  input  logic       clk,
  input  logic       rst_n,
  fxp_mac_if.slave   bus
);

  localparam int PW   = 2 * (N - 1);
  localparam int CntW = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 2);
  localparam logic [N-2:0]    SatMag  = SAT_MAG[N-2:0];

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [PW-1:0]   mcand;
  logic [N-2:0]    mplier;
  logic [PW-1:0]   prod;
  logic            p_sign;
  logic [N-1:0]    acc;
  logic            ovf;
  logic            out_valid_r;
  logic            in_ready_r;

  logic            prod_hi;
  logic [N-2:0]    prod_mag;
  logic [N-1:0]    prod_sm;
  logic [N-1:0]    add_sum;
  logic            add_carry;
  logic [N-1:0]    acc_next;
  logic            unused_lsbs;

  // Fractional bits below the kept window are dropped by truncation.
  assign unused_lsbs = ^prod[Q-1:0];

  // Truncate the full product to the word format, saturating when integer bits spill over.
  always_comb begin
    prod_hi  = |prod[PW-1:N-1+Q];
    prod_mag = prod_hi ? SatMag : prod[N-2+Q:Q];
    prod_sm  = {p_sign & (|prod_mag), prod_mag};
    acc_next = add_carry ? {acc[N-1], SatMag} : add_sum;
  end

  adder #(
    .Q (Q),
    .N (N)
  ) u_adder (
    .a     (acc),
    .b     (prod_sm),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Control FSM plus multiplier and accumulator datapath, all with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      prod        <= '0;
      p_sign      <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            acc <= '0;
            ovf <= 1'b0;
          end
          if (bus.in_valid) begin
            mcand      <= {{(N-1){1'b0}}, bus.a[N-2:0]};
            mplier     <= bus.b[N-2:0];
            p_sign     <= (bus.a[N-1] & (|bus.a[N-2:0])) ^ (bus.b[N-1] & (|bus.b[N-2:0]));
            prod       <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            prod <= prod + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == CntLast) begin
            state <= ACC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACC: begin
          acc <= acc_next;
          if (prod_hi || add_carry) begin
            ovf <= 1'b1;
          end
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          in_ready_r <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.acc_out   = acc;
  assign bus.out_valid = out_valid_r;
  assign bus.overflow  = ovf;

endmodule
